// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream controller: register map, status bits, FSM states.
package uart_pkg;

  localparam logic [3:0] OFF_CLK_DIV = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_DATA    = 4'h8;

  localparam int unsigned STATUS_TX_READY_BIT = 0;
  localparam int unsigned STATUS_RX_READY_BIT = 1;

  typedef enum logic [1:0] {
    ST_CFG,
    ST_POLL,
    ST_RX_READ,
    ST_TX_WRITE
  } state_t;

endpackage

// File: rtl/uart_stream_ctrl_if.sv
// Memory-mapped UART register port; master is the sequencer, slave is the UART.
interface uart_stream_ctrl_if;
  logic [63:0] uart_address_out;
  logic        uart_sel_out;
  logic        uart_read_out;
  logic [63:0] uart_read_value_in;
  logic [3:0]  uart_write_mask_out;
  logic [63:0] uart_write_value_out;

  modport master (
    output uart_address_out, uart_sel_out, uart_read_out,
           uart_write_mask_out, uart_write_value_out,
    input  uart_read_value_in
  );

  modport slave (
    input  uart_address_out, uart_sel_out, uart_read_out,
           uart_write_mask_out, uart_write_value_out,
    output uart_read_value_in
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO with active-low synchronous reset.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/uart_stream_ctrl.sv
// Sequencer owning the UART register port: configures the divider, polls status,
// and moves words between the tx/rx streams and the UART data register.
module uart_stream_ctrl #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [31:0] DEFAULT_CLK_DIV = 32'd217,
  parameter logic [63:0] BASE_ADDR       = 64'h0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [15:0]         tx_data_in,
  input  logic                tx_valid_in,
  output logic                tx_ready_out,
  output logic [15:0]         rx_data_out,
  output logic                rx_valid_out,
  input  logic                rx_ready_in,
  input  logic [31:0]         cfg_div_in,
  input  logic                cfg_div_valid_in,
  uart_stream_ctrl_if.master  uart
);

  import uart_pkg::*;

  state_t      state;
  logic [31:0] div_reg;
  logic        cfg_pending;

  logic        tx_full, tx_empty, tx_push, tx_pop;
  logic [15:0] tx_head;
  logic        rx_full, rx_empty, rx_push, rx_pop;
  logic [1:0]  status;
  logic        unused_read_bits;

  assign status           = uart.uart_read_value_in[1:0];
  assign unused_read_bits = ^uart.uart_read_value_in[63:16];

  assign tx_push = tx_valid_in && !tx_full;
  assign tx_pop  = (state == ST_TX_WRITE);
  assign rx_push = (state == ST_RX_READ);
  assign rx_pop  = rx_ready_in && !rx_empty;

  assign tx_ready_out = reset_n && !tx_full;
  assign rx_valid_out = reset_n && !rx_empty;

  uart_sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tx_push),
    .push_data (tx_data_in),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  uart_sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_push),
    .push_data (uart.uart_read_value_in[15:0]),
    .pop       (rx_pop),
    .pop_data  (rx_data_out),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_CFG;
      div_reg     <= DEFAULT_CLK_DIV;
      cfg_pending <= 1'b0;
    end else begin
      case (state)
        ST_POLL: begin
          if (status[STATUS_RX_READY_BIT] && !rx_full)
            state <= ST_RX_READ;
          else if (cfg_pending && status[STATUS_TX_READY_BIT] && tx_empty)
            state <= ST_CFG;
          else if (status[STATUS_TX_READY_BIT] && !tx_empty)
            state <= ST_TX_WRITE;
          else
            state <= ST_POLL;
        end
        default: state <= ST_POLL;
      endcase
      // A request landing on the CFG cycle keeps pending set so the new value is written too.
      if (cfg_div_valid_in) begin
        div_reg     <= cfg_div_in;
        cfg_pending <= 1'b1;
      end else if (state == ST_CFG) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // Bus drive decodes the state register; reset gates it so an in-flight access is dropped.
  logic [63:0] bus_addr;
  logic        bus_sel;
  logic        bus_read;
  logic [3:0]  bus_mask;
  logic [63:0] bus_value;

  always_comb begin
    bus_addr  = '0;
    bus_sel   = 1'b0;
    bus_read  = 1'b0;
    bus_mask  = '0;
    bus_value = '0;
    if (reset_n) begin
      bus_sel = 1'b1;
      case (state)
        ST_CFG: begin
          bus_addr  = BASE_ADDR | {60'b0, OFF_CLK_DIV};
          bus_mask  = 4'b0011;
          bus_value = {32'b0, div_reg};
        end
        ST_POLL: begin
          bus_addr = BASE_ADDR | {60'b0, OFF_STATUS};
        end
        ST_RX_READ: begin
          bus_addr = BASE_ADDR | {60'b0, OFF_DATA};
          bus_read = 1'b1;
        end
        default: begin
          bus_addr  = BASE_ADDR | {60'b0, OFF_DATA};
          bus_mask  = 4'b0001;
          bus_value = {48'b0, tx_head};
        end
      endcase
    end
  end

  assign uart.uart_address_out     = bus_addr;
  assign uart.uart_sel_out         = bus_sel;
  assign uart.uart_read_out        = bus_read;
  assign uart.uart_write_mask_out  = bus_mask;
  assign uart.uart_write_value_out = bus_value;

endmodule

// File: tb/tb_uart_stream_ctrl.sv
// Scoreboard bench for uart_stream_ctrl with a small behavioural UART register model.
module tb_uart_stream_ctrl;

  localparam logic [63:0] BASE = 64'h0000_0000_4000_1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] cfg_div;
  logic        cfg_valid;

  uart_stream_ctrl_if bus ();

  uart_stream_ctrl #(
    .FIFO_DEPTH      (4),
    .DEFAULT_CLK_DIV (32'd217),
    .BASE_ADDR       (BASE)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .tx_data_in       (tx_data),
    .tx_valid_in      (tx_valid),
    .tx_ready_out     (tx_ready),
    .rx_data_out      (rx_data),
    .rx_valid_out     (rx_valid),
    .rx_ready_in      (rx_ready),
    .cfg_div_in       (cfg_div),
    .cfg_div_valid_in (cfg_valid),
    .uart             (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic        rd;
    logic [3:0]  mask;
    logic [63:0] val;
  } acc_t;

  acc_t        exp_q[$];
  logic [15:0] rx_exp_q[$];
  logic [15:0] src_q[$];
  int          total = 0;
  int          bad   = 0;

  // UART model: status and data registers, rx word consumed by a DATA read.
  logic        st_tx = 1'b0;
  logic        rx_avail = 1'b0;
  logic [15:0] rx_word = '0;
  logic        rd_seen = 1'b0;

  always_comb begin
    bus.uart_read_value_in = '0;
    if (bus.uart_address_out == BASE + 64'h4)
      bus.uart_read_value_in = {62'b0, rx_avail, st_tx};
    else if (bus.uart_address_out == BASE + 64'h8)
      bus.uart_read_value_in = {48'b0, rx_word};
  end

  always @(negedge clk)
    rd_seen = bus.uart_sel_out && bus.uart_read_out && (bus.uart_address_out == BASE + 64'h8);

  always @(posedge clk) begin
    if (rd_seen && src_q.size() != 0) void'(src_q.pop_front());
    rx_avail <= (src_q.size() != 0);
    rx_word  <= (src_q.size() != 0) ? src_q[0] : 16'h0;
  end

  // Monitor: every non-POLL access and every rx handshake is matched against the queues.
  acc_t        got;
  acc_t        e;
  logic [15:0] re;
  always @(negedge clk) begin
    got = '{addr: bus.uart_address_out, rd: bus.uart_read_out,
            mask: bus.uart_write_mask_out, val: bus.uart_write_value_out};
    if (bus.uart_sel_out && (got.rd || got.mask != 4'b0)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_access addr=%h rd=%b mask=%b val=%h required=none",
                 got.addr, got.rd, got.mask, got.val);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL access actual addr=%h rd=%b mask=%b val=%h required addr=%h rd=%b mask=%b val=%h",
                   got.addr, got.rd, got.mask, got.val, e.addr, e.rd, e.mask, e.val);
        end
      end
    end
    if (rx_valid && rx_ready) begin
      total++;
      if (rx_exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rx actual=%h required=none", rx_data);
      end else begin
        re = rx_exp_q.pop_front();
        if (rx_data !== re) begin
          bad++;
          $display("FAIL rx_data actual=%h required=%h", rx_data, re);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exp_acc(input logic [63:0] a, input logic r, input logic [3:0] m, input logic [63:0] v);
    exp_q.push_back('{addr: a, rd: r, mask: m, val: v});
  endtask

  task automatic wait_drain(input int unsigned max_cyc, input string name);
    for (int unsigned i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending_accesses=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_rx_drain(input int unsigned max_cyc, input string name);
    for (int unsigned i = 0; i < max_cyc && rx_exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (rx_exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending_rx=%0d required=0", name, rx_exp_q.size());
      rx_exp_q.delete();
    end
  endtask

  task automatic send_tx(input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_tx_timeout actual=ready_low required=ready_high");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    reset_n = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    cfg_div = '0; cfg_valid = 1'b0;

    // Reset state and first accesses after release
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel", 64'(bus.uart_sel_out), 64'd0);
    check("reset_mask", 64'(bus.uart_write_mask_out), 64'd0);
    check("reset_tx_ready", 64'(tx_ready), 64'd0);
    check("reset_rx_valid", 64'(rx_valid), 64'd0);
    exp_acc(BASE, 1'b0, 4'b0011, 64'd217);
    reset_n = 1'b1;
    @(negedge clk);
    check("cfg_sel", 64'(bus.uart_sel_out), 64'd1);
    check("cfg_value", bus.uart_write_value_out, 64'd217);
    @(negedge clk);
    check("poll_addr", bus.uart_address_out, BASE + 64'h4);
    check("poll_read", 64'(bus.uart_read_out), 64'd0);
    check("poll_mask", 64'(bus.uart_write_mask_out), 64'd0);
    check("tx_ready_after_reset", 64'(tx_ready), 64'd1);
    @(posedge clk); #1;

    // Single tx word, bounded latency
    st_tx = 1'b1;
    exp_acc(BASE + 64'h8, 1'b0, 4'b0001, 64'h00A5);
    send_tx(16'h00A5);
    wait_drain(3, "tx_latency");
    check("tx_ready_stays", 64'(tx_ready), 64'd1);

    // Rx takes priority over a pending tx word
    st_tx = 1'b0;
    send_tx(16'h1234);
    repeat (4) @(posedge clk);
    #1;
    exp_acc(BASE + 64'h8, 1'b1, 4'b0000, 64'd0);
    exp_acc(BASE + 64'h8, 1'b0, 4'b0001, 64'h1234);
    rx_exp_q.push_back(16'h003C);
    src_q.push_back(16'h003C);
    @(posedge clk); #1;
    st_tx = 1'b1;
    wait_drain(10, "rx_before_tx");
    wait_rx_drain(10, "rx_first_word");

    // Rx backpressure: FIFO fills, FSM stops reading until a pop
    st_tx = 1'b0;
    rx_ready = 1'b0;
    src_q.push_back(16'h0011); src_q.push_back(16'h0022); src_q.push_back(16'h0033);
    src_q.push_back(16'h0044); src_q.push_back(16'h0055);
    for (int i = 0; i < 4; i++) exp_acc(BASE + 64'h8, 1'b1, 4'b0000, 64'd0);
    wait_drain(40, "rx_fill");
    repeat (20) @(posedge clk);
    #1;
    check("rx_full_valid", 64'(rx_valid), 64'd1);
    check("rx_full_head", 64'(rx_data), 64'h0011);
    check("rx_full_poll_only", bus.uart_address_out, BASE + 64'h4);
    exp_acc(BASE + 64'h8, 1'b1, 4'b0000, 64'd0);
    rx_exp_q.push_back(16'h0011);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    wait_drain(10, "rx_after_pop");
    rx_exp_q.push_back(16'h0022); rx_exp_q.push_back(16'h0033);
    rx_exp_q.push_back(16'h0044); rx_exp_q.push_back(16'h0055);
    rx_ready = 1'b1;
    wait_rx_drain(20, "rx_drain");

    // Divider rewrite waits for queued tx words; only the last value is written
    st_tx = 1'b0;
    send_tx(16'h0101);
    send_tx(16'h0202);
    cfg_div = 32'd100; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_div = 32'd50;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    exp_acc(BASE + 64'h8, 1'b0, 4'b0001, 64'h0101);
    exp_acc(BASE + 64'h8, 1'b0, 4'b0001, 64'h0202);
    exp_acc(BASE, 1'b0, 4'b0011, 64'd50);
    repeat (5) @(posedge clk);
    #1;
    st_tx = 1'b1;
    wait_drain(20, "cfg_after_tx");
    repeat (10) @(posedge clk);
    #1;

    // Reset during TX_WRITE: access suppressed, FIFOs flushed, default divider rewritten
    rx_ready = 1'b0;
    src_q.push_back(16'h0077);
    exp_acc(BASE + 64'h8, 1'b1, 4'b0000, 64'd0);
    wait_drain(10, "rx_before_reset");
    @(posedge clk); #1;
    check("rx_valid_before_reset", 64'(rx_valid), 64'd1);
    st_tx = 1'b0;
    send_tx(16'h0BAD);
    send_tx(16'h0BEE);
    st_tx = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.uart_write_mask_out == 4'b0001) begin found = 1'b1; break; end
    end
    reset_n = 1'b0;
    check("tx_write_reached", 64'(found), 64'd1);
    @(negedge clk);
    check("reset_mid_sel", 64'(bus.uart_sel_out), 64'd0);
    check("reset_mid_mask", 64'(bus.uart_write_mask_out), 64'd0);
    exp_acc(BASE, 1'b0, 4'b0011, 64'd217);
    @(posedge clk);
    @(posedge clk); #1;
    check("reset2_tx_ready", 64'(tx_ready), 64'd0);
    check("reset2_rx_valid", 64'(rx_valid), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("flushed_tx_ready", 64'(tx_ready), 64'd1);
    check("flushed_rx_valid", 64'(rx_valid), 64'd0);
    wait_drain(5, "cfg_after_reset");
    repeat (15) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
